// File: rtl/debounce_multi.sv
// N-channel debouncer: 2-FF sync, shared sample tick, per-channel qualification counter.
// Outputs switch after STABLE_SAMPLES consecutive disagreeing samples, with edge pulses.
module debounce_multi #(
    parameter int CHANNELS       = 4,
    parameter int TICK_CYCLES    = 50000,
    parameter int STABLE_SAMPLES = 10,
    parameter bit ACTIVE_LOW     = 1'b0,
    parameter bit RESET_VAL      = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                changed
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int CW = $clog2(STABLE_SAMPLES + 1);

    localparam logic [TW-1:0]       TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [CW-1:0]       CNT_LAST  = CW'(STABLE_SAMPLES - 1);
    localparam logic [CHANNELS-1:0] RST_VEC   = {CHANNELS{RESET_VAL}};
    localparam logic [CHANNELS-1:0] INV_VEC   = {CHANNELS{ACTIVE_LOW}};

    logic [CHANNELS-1:0] s1;
    logic [CHANNELS-1:0] s2;
    logic [CHANNELS-1:0] sw;
    logic [TW-1:0]       tcnt;
    logic                tick;
    logic [CW-1:0]       cnt [CHANNELS];

    // Two-stage synchroniser; polarity fixed up before the first flop
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= RST_VEC;
            s2 <= RST_VEC;
        end else begin
            s1 <= in ^ INV_VEC;
            s2 <= s1;
        end
    end

    assign tick = (tcnt == TICK_LAST);

    // Shared prescaler producing one sample tick every TICK_CYCLES clocks
    always_ff @(posedge clk) begin
        if (rst || tick) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end

    // A channel switches on the tick that completes its qualification run
    always_comb begin
        sw = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sw[i] = tick && (s2[i] != out[i]) && (cnt[i] == CNT_LAST);
        end
    end

    // Per-channel run length of consecutive disagreeing samples
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (rst) begin
                cnt[i] <= '0;
            end else if (tick) begin
                if (s2[i] == out[i] || sw[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Debounced level and single-cycle edge pulses, registered together
    always_ff @(posedge clk) begin
        if (rst) begin
            out     <= RST_VEC;
            rise    <= '0;
            fall    <= '0;
            changed <= 1'b0;
        end else begin
            out     <= out ^ sw;
            rise    <= sw & s2;
            fall    <= sw & ~s2;
            changed <= |sw;
        end
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: step-response table plus hand-built glitch/reset sequences.
// Expected values are queued with their due cycle and compared when that cycle arrives.
module tb_debounce_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din, din2;
    logic [3:0] dout, rise, fall;
    logic [3:0] dout2, rise2, fall2;
    logic       chg, chg2;

    always #5 clk = ~clk;

    debounce_multi #(
        .CHANNELS(4), .TICK_CYCLES(4), .STABLE_SAMPLES(3),
        .ACTIVE_LOW(1'b0), .RESET_VAL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .in(din), .out(dout),
        .rise(rise), .fall(fall), .changed(chg)
    );

    debounce_multi #(
        .CHANNELS(4), .TICK_CYCLES(1), .STABLE_SAMPLES(1),
        .ACTIVE_LOW(1'b1), .RESET_VAL(1'b0)
    ) dut2 (
        .clk(clk), .rst(rst), .in(din2), .out(dout2),
        .rise(rise2), .fall(fall2), .changed(chg2)
    );

    typedef struct {
        int         at;
        bit         d2;
        logic [3:0] o;
        logic [3:0] r;
        logic [3:0] f;
        logic       c;
        string      nm;
    } exp_t;

    typedef struct {
        logic [3:0] in;
        logic [3:0] o;
        logic [3:0] r;
        logic [3:0] f;
        logic       c;
    } vec_t;

    exp_t q[$];
    vec_t tbl[7];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int base   = 0;
    int rise_n = 0;
    int fall_n = 0;
    int d2_n   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h",
                     nm, cyc, act, req);
        end
    endtask

    task automatic expect_at(input int at, input bit d2,
                             input logic [3:0] o, input logic [3:0] r,
                             input logic [3:0] f, input logic c,
                             input string nm);
        exp_t e;
        e.at = at;
        e.d2 = d2;
        e.o  = o;
        e.r  = r;
        e.f  = f;
        e.c  = c;
        e.nm = nm;
        q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        logic [31:0] act;
        @(posedge clk);
        #1;
        cyc++;
        if (|rise) rise_n++;
        if (|fall) fall_n++;
        if (|{rise2, fall2}) d2_n++;
        while (q.size() > 0 && q[0].at <= cyc) begin
            e = q.pop_front();
            if (e.at < cyc) begin
                chk({e.nm, "_late"}, 32'(cyc), 32'(e.at));
            end else begin
                act = e.d2 ? 32'({dout2, rise2, fall2, chg2})
                           : 32'({dout, rise, fall, chg});
                chk(e.nm, act, 32'({e.o, e.r, e.f, e.c}));
            end
        end
    endtask

    // Drive point chosen so the first sampling tick lands 3 edges later
    task automatic align();
        while ((((cyc + 3 - base) % 4) + 4) % 4 != 0) step();
    endtask

    initial begin
        int k;
        int rn;
        int fn;
        logic [3:0] prev;

        tbl[0] = '{4'h0, 4'h0, 4'h0, 4'hF, 1'b1};
        tbl[1] = '{4'h1, 4'h1, 4'h1, 4'h0, 1'b1};
        tbl[2] = '{4'h5, 4'h5, 4'h4, 4'h0, 1'b1};
        tbl[3] = '{4'hA, 4'hA, 4'hA, 4'h5, 1'b1};
        tbl[4] = '{4'hA, 4'hA, 4'h0, 4'h0, 1'b0};
        tbl[5] = '{4'h3, 4'h3, 4'h1, 4'h8, 1'b1};
        tbl[6] = '{4'h0, 4'h0, 4'h0, 4'h3, 1'b1};

        rst  = 1'b1;
        din  = 4'hF;
        din2 = 4'hF;

        // reset held 5 cycles with inputs high, then release
        for (int c = 1; c <= 5; c++)
            expect_at(c, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, "reset_hold");
        expect_at(16, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, "t1_before");
        expect_at(17, 1'b0, 4'hF, 4'hF, 4'h0, 1'b1, "t1_rise");
        expect_at(18, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0, "t1_after");
        repeat (5) step();
        rst  = 1'b0;
        base = cyc + 4;
        while (cyc < 18) step();
        chk("d2_idle_pulses", 32'(d2_n), 32'd0);
        expect_at(cyc + 1, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, "d2_idle");
        step();

        // step responses from the table, 11-cycle latency when aligned
        prev = 4'hF;
        for (int i = 0; i < 7; i++) begin
            align();
            k   = cyc;
            din = tbl[i].in;
            expect_at(k + 10, 1'b0, prev, 4'h0, 4'h0, 1'b0, "tbl_before");
            expect_at(k + 11, 1'b0, tbl[i].o, tbl[i].r, tbl[i].f, tbl[i].c,
                      "tbl_edge");
            expect_at(k + 12, 1'b0, tbl[i].o, 4'h0, 4'h0, 1'b0, "tbl_after");
            while (cyc < k + 12) step();
            prev = tbl[i].o;
        end

        // short pulse on channel 1 seen on only two ticks
        align();
        k   = cyc;
        rn  = rise_n;
        fn  = fall_n;
        din = 4'h2;
        repeat (6) step();
        din = 4'h0;
        expect_at(k + 20, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, "t3_hold");
        while (cyc < k + 20) step();
        chk("t3_no_pulse", 32'((rise_n - rn) + (fall_n - fn)), 32'd0);

        // channel 2 set, then periodic one-cycle low glitches
        align();
        k   = cyc;
        din = 4'h4;
        expect_at(k + 11, 1'b0, 4'h4, 4'h4, 4'h0, 1'b1, "t4_set");
        expect_at(k + 12, 1'b0, 4'h4, 4'h0, 4'h0, 1'b0, "t4_set_after");
        while (cyc < k + 12) step();
        fn = fall_n;
        for (int j = 0; j < 60; j++) begin
            din = (j % 5 == 0) ? 4'h0 : 4'h4;
            step();
        end
        din = 4'h4;
        repeat (4) step();
        expect_at(cyc + 1, 1'b0, 4'h4, 4'h0, 4'h0, 1'b0, "t4_hold");
        step();
        chk("t4_no_fall", 32'(fall_n - fn), 32'd0);

        // reset after two qualifying ticks on channel 3
        align();
        k   = cyc;
        rn  = rise_n;
        fn  = fall_n;
        din = 4'hC;
        expect_at(k + 8,  1'b0, 4'h4, 4'h0, 4'h0, 1'b0, "t5_pre_rst");
        expect_at(k + 9,  1'b0, 4'h0, 4'h0, 4'h0, 1'b0, "t5_in_rst");
        expect_at(k + 20, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, "t5_requal");
        expect_at(k + 21, 1'b0, 4'hC, 4'hC, 4'h0, 1'b1, "t5_rise");
        expect_at(k + 22, 1'b0, 4'hC, 4'h0, 4'h0, 1'b0, "t5_after");
        while (cyc < k + 8) step();
        rst = 1'b1;
        step();
        rst  = 1'b0;
        base = cyc + 4;
        while (cyc < k + 20) step();
        chk("t5_no_pulse", 32'((rise_n - rn) + (fall_n - fn)), 32'd0);
        while (cyc < k + 22) step();

        // active-low, tick every cycle, single sample
        k    = cyc;
        din2 = 4'hE;
        expect_at(k + 2, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, "t6_before");
        expect_at(k + 3, 1'b1, 4'h1, 4'h1, 4'h0, 1'b1, "t6_rise");
        expect_at(k + 4, 1'b1, 4'h1, 4'h0, 4'h0, 1'b0, "t6_after");
        while (cyc < k + 4) step();
        k    = cyc;
        din2 = 4'hF;
        expect_at(k + 2, 1'b1, 4'h1, 4'h0, 4'h0, 1'b0, "t6_fall_before");
        expect_at(k + 3, 1'b1, 4'h0, 4'h0, 4'h1, 1'b1, "t6_fall");
        expect_at(k + 4, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, "t6_fall_after");
        while (cyc < k + 4) step();

        repeat (2) step();
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
